uart_byte_rx: RTL and testbench

Oversampling UART receiver that deserialises the board's incoming serial line (8N1, optional parity) into bytes. Presents each byte on a valid/ready output to the CPU-side peripheral logic, and flags framing, parity and overrun errors. It is the receive-side counterpart of the UART transmit path that drives the board's serial output pin.

---
 rtl/uart_byte_rx.sv | 202 ++++++++++++++++++++
 tb/tb_uart_byte_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 16x oversampling UART receiver (8N1) with a valid/ready byte output.
// Define UART_BYTE_RX_PARITY_EN to add a parity bit; PARITY_ODD then selects odd parity.
module uart_byte_rx #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 115200
`ifdef UART_BYTE_RX_PARITY_EN
  ,
  parameter int unsigned PARITY_ODD = 0
`endif
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESET,
  input  logic       uart_rxd,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
  localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_BYTE_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitHigh
  } state_e;

  state_e        state_q, state_d;
  logic          rx_meta, rxs;
  logic [CW-1:0] div_q;
  logic          tick;
  logic [3:0]    sub_q, sub_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          stop_hit;
  logic          byte_good;

  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rxs     <= rx_meta;
    end
  end

  // Held at zero in IDLE so the first tick of a frame lands DIV cycles after the start edge.
  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      div_q <= '0;
    end else if (state_q == StIdle || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + CW'(1);
    end
  end

  assign tick = (div_q == CW'(DIV - 1));

`ifdef UART_BYTE_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
`endif

  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    stop_hit = 1'b0;
`ifdef UART_BYTE_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rxs) begin
          state_d = StStart;
          sub_d   = 4'd0;
        end
      end
      StStart: begin
        if (tick) begin
          if (sub_q == 4'd7) begin
            sub_d   = 4'd0;
            bit_d   = 3'd0;
            state_d = rxs ? StIdle : StData;
`ifdef UART_BYTE_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            shift_d = {rxs, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_BYTE_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end
        end
      end
`ifdef UART_BYTE_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            par_bad_d = ((^shift_q) ^ rxs) != 1'(PARITY_ODD);
            state_d   = StStop;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            stop_hit = 1'b1;
            state_d  = rxs ? StIdle : StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        if (rxs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      state_q <= StIdle;
      sub_q   <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

`ifdef UART_BYTE_RX_PARITY_EN
  // The parity verdict is held until the stop sample so both error flags pulse together.
  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      par_bad_q  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad_q  <= par_bad_d;
      parity_err <= stop_hit & par_bad_q;
    end
  end

  assign byte_good = stop_hit & rxs & ~par_bad_q;
`else
  assign parity_err = 1'b0;
  assign byte_good  = stop_hit & rxs;
`endif

  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      m_data    <= 8'd0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_hit & ~rxs;
      overrun   <= byte_good & m_valid & ~m_ready;
      if (byte_good && (!m_valid || m_ready)) begin
        m_data  <= shift_q;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed and randomized frames against a frame-level model of the receiver.
// Expected bytes/flags come from what was put on the line, not from the receiver's internals.
module tb_uart_byte_rx;

  localparam int unsigned CLK_FREQ = 16000000;
  localparam int unsigned BAUD     = 1000000;
`ifdef UART_BYTE_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Negedges from the pin falling (just after a posedge) to the first m_valid sample:
  // 2 sync cycles + start/data/parity sampling + 1 register cycle + 1 for negedge alignment.
  localparam int LAT       = 2 + 8 + 16 * (NBITS - 1) + 2;
  // Posedges from the pin falling to the start of the stop-sample cycle.
  localparam int STOP_EDGE = 2 + 8 + 16 * (NBITS - 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_byte_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESET (rst),
    .uart_rxd  (rxd),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         fall_cyc = 0;
  int         vcnt = 0;
  int         fe_cnt = 0;
  int         pe_cnt = 0;
  int         ov_cnt = 0;
  logic [7:0] got_q[$];
  int         got_cyc[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      got_cyc.push_back(cyc + 1);
    end
    if (m_valid)    vcnt   <= vcnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
    if (parity_err) pe_cnt <= pe_cnt + 1;
    if (overrun)    ov_cnt <= ov_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    tick(16);
  endtask

  function automatic int dpar(input logic [7:0] b);
`ifdef UART_BYTE_RX_PARITY_EN
    return int'(^b);
`else
    return -1 + int'(b & 8'h00);
`endif
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int par);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (par >= 0) drive_bit(par[0]);
    if (stop_ok) begin
      drive_bit(1'b1);
    end else begin
      drive_bit(1'b0);
      rxd = 1'b1;
      tick(4);
    end
  endtask

  function automatic logic [7:0] got_at(input int idx);
    return (got_q.size() > idx) ? got_q[idx] : 8'hxx;
  endfunction

  initial begin
    int         base;
    int         fe0;
    int         ov0;
    int         pe0;
    int         v0;
    int         fe_exp;
    logic [7:0] b;
    bit         ok;
    logic [7:0] exp_q[$];

    rst     = 1'b1;
    rxd     = 1'b1;
    m_ready = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_parity_err", parity_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(4);

    // Basic byte with latency measured from the pin edge.
    base = got_q.size(); v0 = vcnt; fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1, dpar(8'hA5));
    tick(6);
    chk("a5_count", got_q.size() - base, 1);
    chk("a5_data", got_at(base), 8'hA5);
    chk("a5_latency", (got_cyc.size() > base) ? got_cyc[base] - fall_cyc : -1, LAT);
    chk("a5_valid_cycles", vcnt - v0, 1);
    chk("a5_flags", {fe_cnt - fe0, pe_cnt - pe0, ov_cnt - ov0}, 0);

    // Short low glitch is a false start.
    base = got_q.size(); v0 = vcnt; fe0 = fe_cnt;
    rxd = 1'b0;
    tick(3);
    @(negedge clk);
    chk("glitch_busy_on", busy, 1'b1);
    @(posedge clk);
    #1 rxd = 1'b1;
    tick(7);
    @(negedge clk);
    chk("glitch_busy_off", busy, 1'b0);
    tick(20);
    chk("glitch_no_valid", vcnt - v0, 0);
    chk("glitch_no_flags", {fe_cnt - fe0, pe_cnt - pe0, ov_cnt - ov0}, 0);

    // Framing error then recovery.
    base = got_q.size(); v0 = vcnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, dpar(8'h3C));
    tick(4);
    chk("fe_pulse", fe_cnt - fe0, 1);
    chk("fe_no_valid", vcnt - v0, 0);
    send_frame(8'h55, 1'b1, dpar(8'h55));
    tick(4);
    chk("fe_next_count", got_q.size() - base, 1);
    chk("fe_next_data", got_at(base), 8'h55);

    // Overrun: the second byte is discarded, the first is kept.
    m_ready = 1'b0;
    base = got_q.size(); ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, dpar(8'h11));
    send_frame(8'h22, 1'b1, dpar(8'h22));
    tick(4);
    @(negedge clk);
    chk("ovr_pulse", ov_cnt - ov0, 1);
    chk("ovr_m_data", m_data, 8'h11);
    chk("ovr_m_valid", m_valid, 1'b1);
    @(posedge clk);
    #1 m_ready = 1'b1;
    tick(6);
    chk("ovr_drain_count", got_q.size() - base, 1);
    chk("ovr_drain_data", got_at(base), 8'h11);
    chk("ovr_drain_valid", m_valid, 1'b0);

    // Handshake in the very cycle the next byte completes.
    m_ready = 1'b0;
    base = got_q.size(); ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, dpar(8'h11));
    fork
      send_frame(8'h22, 1'b1, dpar(8'h22));
      begin
        tick(STOP_EDGE);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
      end
    join
    @(negedge clk);
    chk("coinc_m_data", m_data, 8'h22);
    chk("coinc_m_valid", m_valid, 1'b1);
    chk("coinc_no_overrun", ov_cnt - ov0, 0);
    chk("coinc_first", got_at(base), 8'h11);
    m_ready = 1'b1;
    tick(4);
    chk("coinc_second", got_at(base + 1), 8'h22);

`ifdef UART_BYTE_RX_PARITY_EN
    base = got_q.size(); pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 0);
    tick(4);
    chk("par_bad_pulse", pe_cnt - pe0, 1);
    chk("par_bad_dropped", got_q.size() - base, 0);
    send_frame(8'h07, 1'b1, 1);
    tick(4);
    chk("par_good_data", got_at(base), 8'h07);
`endif

    // Randomized frames: good ones must arrive in order, bad-stop ones only raise frame_err.
    m_ready = 1'b1;
    base = got_q.size(); fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    fe_exp = 0;
    for (int k = 0; k < 12; k++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(3) != 0);
      if (ok) exp_q.push_back(b);
      else fe_exp++;
      send_frame(b, ok, dpar(b));
      tick($urandom_range(5));
    end
    tick(20);
    chk("rnd_count", got_q.size() - base, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      chk($sformatf("rnd_byte%0d", k), got_at(base + k), exp_q[k]);
    end
    chk("rnd_frame_err", fe_cnt - fe0, fe_exp);
    chk("rnd_no_other", {pe_cnt - pe0, ov_cnt - ov0}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
